light_hash_param: RTL and testbench
===================================

// Module: light_hash_param
// PURPOSE
// - Parametrised next-generation light hash. Absorbs a byte stream framed by head/message/tail commands.
// - Digest is DIGEST_BYTES lanes of 8 bits, mixed over ROUNDS iterations of a per-lane AES S-box round.
// - Exposes an explicit byte_ready handshake, so the upstream feeder or bench paces itself on that signal.
// - Sits between the message source and the digest consumer.
// PARAMETERS
// - DIGEST_BYTES  8                              number of 8-bit lanes N; digest width = 8*N (N >= 1)
// - ROUNDS        32                             rounds per absorbed byte (1..255)
// - IV            64'h0123_4567_89AB_CDEF        initial lane values, 8*N bits; lane i = IV[8i+7:8i]
// PORTS
// - clk            in   1    single clock, rising edge
// - rst_n          in   1    asynchronous, active-low reset
// - message_byte   in   8    data byte, sampled with cmd MSG
// - message_valid  in   1    command strobe; sampled only while byte_ready=1
// - state          in   2    command: 2'b00 HEAD, 2'b10 MSG, 2'b01 TAIL, 2'b11 NOP
// - byte_ready     out  1    1 = block can accept a command this cycle
// - digest         out  8*N  final digest; lane i is on digest[8i+7:8i]
// - digest_ready   out  1    1 = digest holds the result of the last TAIL
// BEHAVIOUR
// - Reset values:
//   - lanes H[i] = IV lane i; length counter len = 0
//   - digest = 0, digest_ready = 0, byte_ready = 1; FSM in IDLE
// - Commands are accepted only when message_valid=1 and byte_ready=1. Otherwise they are ignored (no queuing).
// - FSM states: IDLE, ABSORB, PAD (PAD exists only with the macro).
// - HEAD (IDLE -> IDLE):
//   - next cycle: H = IV, len = 0, digest_ready = 0
//   - digest keeps its old value
// - MSG (IDLE -> ABSORB):
//   - latch m = message_byte; len = len + 1 (mod 2^32); round counter r = 0; digest_ready = 0
//   - byte_ready = 0 from the next cycle
// - ABSORB round (one round per clk, r = 0..ROUNDS-1). All lanes update in parallel from the old values:
//   - H'[i] = SBOX(H[(i+1) mod N] ^ m ^ r[7:0]) ^ rotl3(H[i])
//   - rotl3(x) = {x[4:0], x[7:5]}; SBOX = AES S-box (FIPS-197), one combinational instance per lane
//   - After round ROUNDS-1: return to IDLE, byte_ready = 1.
//   - Timing: MSG accepted at edge T -> byte_ready low for exactly ROUNDS cycles, high again at T+ROUNDS+1.
// - TAIL without the macro (IDLE -> IDLE):
//   - next cycle: digest = {H[N-1], ..., H[0]}, digest_ready = 1
//   - H and len are unchanged, so a repeated TAIL gives the same digest
// - Holding behaviour:
//   - digest_ready stays 1 until the next accepted HEAD or MSG
//   - digest holds until the next TAIL completes
// - MSG without a prior HEAD is legal: it chains from the current H.
// - NOP, or any command while byte_ready=0, has no effect.
// - Reset asserted mid-ABSORB or mid-PAD: immediate return to reset values. The partial round is discarded.
// CONFIGURATION
// - LH_LEN_PAD_EN defined:
//   - TAIL enters PAD and absorbs the 4 bytes of len, LSB first, each through the full ROUNDS-round ABSORB function
//   - byte_ready = 0 throughout PAD
//   - digest and digest_ready = 1 update on the edge after the last pad round: TAIL at T -> digest_ready at T+4*ROUNDS+1
//   - len is not incremented by the pad bytes; H is left in its post-pad state
// - LH_LEN_PAD_EN undefined:
//   - no PAD state; TAIL latency is 1 cycle; len is still counted but unused
// TESTING
// - Reset: hold rst_n=0 -> digest=0, digest_ready=0, byte_ready=1. HEAD then TAIL -> digest=IV 1 cycle after TAIL.
// - Round function, N=1, ROUNDS=1, IV=8'h00, pad off:
//   - HEAD, MSG 8'h00, TAIL -> digest=8'h63
//   - HEAD, MSG 8'h53, TAIL -> digest=8'hED
// - Timing, defaults: MSG at T -> byte_ready=0 for cycles T+1..T+32, 1 at T+33. MSG strobed at T+5 is ignored (len stays 1).
// - Avalanche: "AlessandroAndGiacomo" vs "AlessandroandGiacomo" -> the two digests differ, with >=16 bits differing.
// - Reset mid-ABSORB at round 10 -> byte_ready=1 and H=IV immediately. HEAD, TAIL -> digest=IV.
// - LH_LEN_PAD_EN, defaults: HEAD, TAIL -> digest_ready at T+129; digest != IV; "a" vs "a\0" give different digests.

Source files
------------

// File: rtl/light_hash_param.sv
// Light hash: absorbs HEAD/MSG/TAIL framed bytes into DIGEST_BYTES S-box lanes; LH_LEN_PAD_EN adds length padding on TAIL.
// Latency: MSG busy for ROUNDS cycles; TAIL 1 cycle (4*ROUNDS+1 with LH_LEN_PAD_EN).
// Backpressure: byte_ready low while absorbing/padding; commands strobed then are dropped, not queued.
module light_hash_param #(
   parameter int unsigned                DIGEST_BYTES = 8,
   parameter int unsigned                ROUNDS       = 32,
   parameter logic [8*DIGEST_BYTES-1:0]  IV           = 64'h0123_4567_89AB_CDEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    message_byte,
   input  logic                          message_valid,
   input  logic [1:0]                    state,
   output logic                          byte_ready,
   output logic [8*DIGEST_BYTES-1:0]     digest,
   output logic                          digest_ready
);

   localparam logic [1:0] CMD_HEAD = 2'b00;
   localparam logic [1:0] CMD_MSG  = 2'b10;
   localparam logic [1:0] CMD_TAIL = 2'b01;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef LH_LEN_PAD_EN
   typedef enum logic [1:0] {IDLE, ABSORB, PAD} fsm_t;
   logic [1:0] pad_idx_q;
`else
   typedef enum logic [1:0] {IDLE, ABSORB} fsm_t;
`endif

   fsm_t                        fsm_q, fsm_d;
   logic [8*DIGEST_BYTES-1:0]   lanes_q, round_out, digest_q;
   logic [31:0]                 len_q;
   logic [7:0]                  m_q, r_q;
   logic                        digest_rdy_q;
   logic                        last_round;

   assign last_round   = (r_q == 8'(ROUNDS - 1));
   assign digest       = digest_q;
   assign digest_ready = digest_rdy_q;

   // All lanes update together from the pre-round values.
   for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_lane
      localparam int unsigned NB = (i + 1) % DIGEST_BYTES;
      logic [7:0] sb_in;
      assign sb_in = lanes_q[8*NB +: 8] ^ m_q ^ r_q;
      assign round_out[8*i +: 8] = SBOX[sb_in] ^ {lanes_q[8*i +: 5], lanes_q[8*i+5 +: 3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d      = fsm_q;
      byte_ready = 1'b0;
      case (fsm_q)
         IDLE: begin
            byte_ready = 1'b1;
            if (message_valid && state == CMD_MSG) fsm_d = ABSORB;
`ifdef LH_LEN_PAD_EN
            if (message_valid && state == CMD_TAIL) fsm_d = PAD;
`endif
         end
         ABSORB: if (last_round) fsm_d = IDLE;
`ifdef LH_LEN_PAD_EN
         PAD: if (last_round && pad_idx_q == 2'd3) fsm_d = IDLE;
`endif
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes_q      <= IV;
         len_q        <= '0;
         m_q          <= '0;
         r_q          <= '0;
         digest_q     <= '0;
         digest_rdy_q <= 1'b0;
`ifdef LH_LEN_PAD_EN
         pad_idx_q    <= '0;
`endif
      end else begin
         case (fsm_q)
            IDLE: if (message_valid) begin
               case (state)
                  CMD_HEAD: begin
                     lanes_q      <= IV;
                     len_q        <= '0;
                     digest_rdy_q <= 1'b0;
                  end
                  CMD_MSG: begin
                     m_q          <= message_byte;
                     len_q        <= len_q + 32'd1;
                     r_q          <= '0;
                     digest_rdy_q <= 1'b0;
                  end
                  CMD_TAIL: begin
`ifdef LH_LEN_PAD_EN
                     m_q       <= len_q[7:0];
                     r_q       <= '0;
                     pad_idx_q <= '0;
`else
                     digest_q     <= lanes_q;
                     digest_rdy_q <= 1'b1;
`endif
                  end
                  default: ;
               endcase
            end
            ABSORB: begin
               lanes_q <= round_out;
               r_q     <= r_q + 8'd1;
            end
`ifdef LH_LEN_PAD_EN
            // Length bytes go through the same absorb rounds, LSB first, without counting.
            PAD: begin
               lanes_q <= round_out;
               r_q     <= r_q + 8'd1;
               if (last_round) begin
                  r_q <= '0;
                  if (pad_idx_q == 2'd3) begin
                     digest_q     <= round_out;
                     digest_rdy_q <= 1'b1;
                  end else begin
                     pad_idx_q <= pad_idx_q + 2'd1;
                     m_q       <= len_q[{pad_idx_q + 2'd1, 3'b000} +: 8];
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_light_hash_param.sv
// Directed bench: default-size instance plus two tiny instances (N=1/R=1, N=2/R=2) with hand-computed digests.
module tb_light_hash_param;

   localparam logic [1:0] HEAD = 2'b00, MSG = 2'b10, TAIL = 2'b01, NOP = 2'b11;
   localparam logic [63:0] IV_D = 64'h0123_4567_89AB_CDEF;

   logic        clk, rst_n;
   logic [7:0]  mbyte;
   logic [1:0]  cmd;
   logic        vd, v1, v2;
   logic        br_d, br_1, br_2, dr_d, dr_1, dr_2;
   logic [63:0] dg_d;
   logic [7:0]  dg_1;
   logic [15:0] dg_2;
   int          checks = 0, errors = 0;

   light_hash_param d_def (
      .clk(clk), .rst_n(rst_n), .message_byte(mbyte), .message_valid(vd), .state(cmd),
      .byte_ready(br_d), .digest(dg_d), .digest_ready(dr_d));

   light_hash_param #(.DIGEST_BYTES(1), .ROUNDS(1), .IV(8'h00)) d_n1 (
      .clk(clk), .rst_n(rst_n), .message_byte(mbyte), .message_valid(v1), .state(cmd),
      .byte_ready(br_1), .digest(dg_1), .digest_ready(dr_1));

   light_hash_param #(.DIGEST_BYTES(2), .ROUNDS(2), .IV(16'h0100)) d_n2 (
      .clk(clk), .rst_n(rst_n), .message_byte(mbyte), .message_valid(v2), .state(cmd),
      .byte_ready(br_2), .digest(dg_2), .digest_ready(dr_2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic br_of(input int w);
      case (w)
         0:       return br_d;
         1:       return br_1;
         default: return br_2;
      endcase
   endfunction

   task automatic send(input int w, input logic [1:0] c, input logic [7:0] b);
      cmd = c; mbyte = b;
      vd = (w == 0); v1 = (w == 1); v2 = (w == 2);
      @(posedge clk); #1;
      vd = 1'b0; v1 = 1'b0; v2 = 1'b0; cmd = NOP;
   endtask

   task automatic wait_ready(input int w, output int n);
      n = 0;
      while (!br_of(w) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) begin
         errors++;
         $error("FAIL wait_timeout observed %0d cycles expected ready", n);
      end
   endtask

   task automatic hash_str(input string s, output logic [63:0] d);
      int n;
      send(0, HEAD, 8'h00);
      for (int i = 0; i < s.len(); i++) begin
         send(0, MSG, s[i]);
         wait_ready(0, n);
      end
      send(0, TAIL, 8'h00);
      wait_ready(0, n);
      d = dg_d;
   endtask

   initial begin
      int n;
      logic [63:0] ha, hb;
      rst_n = 1'b0; mbyte = '0; cmd = NOP; vd = 0; v1 = 0; v2 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_digest", dg_d, 64'h0);
      check("rst_digest_ready", 64'(dr_d), 64'h0);
      check("rst_byte_ready", 64'(br_d), 64'h1);
      check("rst_len", 64'(d_def.len_q), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // MSG busy window; a strobe mid-absorb must be dropped
      send(0, HEAD, 8'h00);
      send(0, MSG, 8'h41);
      check("busy_after_msg", 64'(br_d), 64'h0);
      repeat (3) @(posedge clk);
      #1;
      send(0, MSG, 8'h42);
      wait_ready(0, n);
      check("busy_remaining", 64'(n), 64'(32 - 4));
      check("len_ignored_msg", 64'(d_def.len_q), 64'h1);

      // async reset mid-absorb
      send(0, MSG, 8'h55);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_byte_ready", 64'(br_d), 64'h1);
      check("midrst_lanes", d_def.lanes_q, IV_D);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

`ifndef LH_LEN_PAD_EN
      send(0, HEAD, 8'h00);
      send(0, TAIL, 8'h00);
      check("iv_digest", dg_d, IV_D);
      check("iv_digest_ready", 64'(dr_d), 64'h1);
      send(0, NOP, 8'h00);
      cmd = HEAD; @(posedge clk); #1; cmd = NOP;
      check("hold_digest_ready", 64'(dr_d), 64'h1);

      hash_str("AlessandroAndGiacomo", ha);
      hash_str("AlessandroandGiacomo", hb);
      check("aval_differ", 64'(ha !== hb), 64'h1);
      check("aval_16bits", 64'($countones(ha ^ hb) >= 16), 64'h1);
      send(0, TAIL, 8'h00);
      check("repeat_tail", dg_d, hb);
      send(0, HEAD, 8'h00);
      check("head_clears_ready", 64'(dr_d), 64'h0);
      check("head_keeps_digest", dg_d, hb);

      send(1, HEAD, 8'h00);
      send(1, MSG, 8'h00);
      wait_ready(1, n);
      check("n1_busy", 64'(n), 64'h1);
      send(1, TAIL, 8'h00);
      check("n1_msg00", 64'(dg_1), 64'h63);
      send(1, MSG, 8'h00);
      wait_ready(1, n);
      send(1, TAIL, 8'h00);
      check("n1_chain", 64'(dg_1), 64'hE0);
      send(1, HEAD, 8'h00);
      send(1, MSG, 8'h53);
      wait_ready(1, n);
      send(1, TAIL, 8'h00);
      check("n1_msg53", 64'(dg_1), 64'hED);

      send(2, HEAD, 8'h00);
      send(2, TAIL, 8'h00);
      check("n2_iv", 64'(dg_2), 64'h0100);
      send(2, HEAD, 8'h00);
      send(2, MSG, 8'h00);
      wait_ready(2, n);
      check("n2_busy", 64'(n), 64'h2);
      send(2, TAIL, 8'h00);
      check("n2_msg00", 64'(dg_2), 64'hA4E1);
`else
      send(0, HEAD, 8'h00);
      send(0, TAIL, 8'h00);
      wait_ready(0, n);
      check("pad_latency", 64'(n), 64'(4 * 32));
      check("pad_digest_ready", 64'(dr_d), 64'h1);
      check("pad_not_iv", 64'(dg_d !== IV_D), 64'h1);
      check("pad_len_kept", 64'(d_def.len_q), 64'h0);
      send(0, HEAD, 8'h00);
      send(0, MSG, 8'h61);
      wait_ready(0, n);
      send(0, TAIL, 8'h00);
      wait_ready(0, n);
      ha = dg_d;
      send(0, HEAD, 8'h00);
      send(0, MSG, 8'h61);
      wait_ready(0, n);
      send(0, MSG, 8'h00);
      wait_ready(0, n);
      send(0, TAIL, 8'h00);
      wait_ready(0, n);
      hb = dg_d;
      check("pad_a_vs_a0", 64'(ha !== hb), 64'h1);
      check("pad_len2", 64'(d_def.len_q), 64'h2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
